syn_fifo: RTL and testbench

SYN_FIFO -- requirements
Module: syn_fifo

---
 rtl/syn_fifo_pkg.sv | 26 ++
 rtl/syn_fifo_if.sv | 31 +++
 rtl/syn_fifo_ram.sv | 34 +++
 rtl/syn_fifo.sv | 96 +++++++++
 tb/tb_syn_fifo.sv | 138 +++++++++++++
 5 files changed

// File: rtl/syn_fifo_pkg.sv
// syn_fifo_pkg: shared constants, helpers and types for the syn_fifo slice.
//   DEF_DATA_WIDTH / DEF_FIFO_DEPTH : default word width and storage depth
//   addr_width()                    : ceil(log2(n)); sizes pointers and usedw
//   fifo_op_e                       : operation accepted on a given clock edge
package syn_fifo_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_FIFO_DEPTH = 256;

    function automatic int unsigned addr_width(input int unsigned depth);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < depth) begin
            w++;
        end
        return w;
    endfunction

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_WR   = 2'b01,
        OP_RD   = 2'b10,
        OP_RW   = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/syn_fifo_if.sv
// syn_fifo_if: FIFO user-side bus.
//   data_in, wrreq, rdreq          : driven by the user (master)
//   data_out, usedw, empty, full   : driven by the FIFO (slave)
// The FIFO and its interface instance must use the same parameter values.
interface syn_fifo_if
    import syn_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
);
    localparam int unsigned AW = addr_width(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] data_in;
    logic                  wrreq;
    logic                  rdreq;
    logic [DATA_WIDTH-1:0] data_out;
    logic [AW-1:0]         usedw;
    logic                  empty;
    logic                  full;

    modport master (
        output data_in, wrreq, rdreq,
        input  data_out, usedw, empty, full
    );

    modport slave (
        input  data_in, wrreq, rdreq,
        output data_out, usedw, empty, full
    );

endinterface

// File: rtl/syn_fifo_ram.sv
// syn_fifo_ram: simple dual-port storage, block-RAM inferable.
//   clk              : single clock
//   wr_en/wr_addr/wr_data : synchronous write port
//   rd_en/rd_addr    : synchronous read request
//   rd_data          : registered read data, holds when rd_en=0
// No reset on contents or on rd_data.
module syn_fifo_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/syn_fifo.sv
// syn_fifo: single-clock FIFO, normal (non show-ahead) read mode.
//   clk   : clock, rising edge
//   arstn : asynchronous reset, active HIGH despite the name
//   bus   : syn_fifo_if.slave (data_in, wrreq, rdreq, data_out, usedw,
//           empty, full)
// Pointers, count and flags live here; storage is syn_fifo_ram.
module syn_fifo
    import syn_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic     clk,
    input  logic     arstn,
    syn_fifo_if.slave bus
);

    localparam int unsigned AW = addr_width(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic                  rd_seen;
    logic [DATA_WIDTH-1:0] ram_q;
    logic                  empty_i;
    logic                  full_i;
    logic                  wr_ok;
    logic                  rd_ok;
    fifo_op_e              op;

    // Flags decode the registered count only, so they never depend
    // combinationally on wrreq/rdreq.
    assign empty_i = (count == '0);
    assign full_i  = (count == FULL_COUNT);

    // Full + both requests admits only the read; empty + both admits only
    // the write, so there is no fall-through.
    assign wr_ok = bus.wrreq & ~full_i;
    assign rd_ok = bus.rdreq & ~empty_i;

    always_comb begin
        op = OP_NONE;
        case ({rd_ok, wr_ok})
            2'b01:   op = OP_WR;
            2'b10:   op = OP_RD;
            2'b11:   op = OP_RW;
            default: op = OP_NONE;
        endcase
    end

    always_ff @(posedge clk or posedge arstn) begin
        if (arstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_seen <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_seen <= 1'b1;
            end
            case (op)
                OP_WR:   count <= count + 1'b1;
                OP_RD:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A read and write can never target the same address on one edge:
    // equal pointers mean empty (read blocked) or full (write blocked).
    syn_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr),
        .wr_data (bus.data_in),
        .rd_en   (rd_ok),
        .rd_addr (rd_ptr),
        .rd_data (ram_q)
    );

    // The RAM output register has no reset; rd_seen (async reset) masks it
    // so data_out reads 0 from reset until the first accepted read.
    assign bus.data_out = rd_seen ? ram_q : '0;
    assign bus.usedw    = count[AW-1:0];
    assign bus.empty    = empty_i;
    assign bus.full     = full_i;

endmodule

// File: tb/tb_syn_fifo.sv
// tb_syn_fifo: directed, scoreboard-based bench for syn_fifo.
module tb_syn_fifo;
    import syn_fifo_pkg::*;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 256;

    logic clk = 1'b0;
    logic arstn;

    syn_fifo_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

    syn_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .arstn (arstn),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] sb [$];
    int unsigned   model_cnt;
    logic [DW-1:0] exp_out;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "/data_out"}, 32'(bus.data_out), 32'(exp_out));
        check({tag, "/usedw"},    32'(bus.usedw),    model_cnt % DEPTH);
        check({tag, "/empty"},    32'(bus.empty),    32'(model_cnt == 0));
        check({tag, "/full"},     32'(bus.full),     32'(model_cnt == DEPTH));
    endtask

    // One clock: drive requests, let the edge happen, update the model,
    // then check 1 time unit after the edge.
    task automatic step(input logic wr, input logic rd, input logic [DW-1:0] din, input string tag);
        logic wr_ok;
        logic rd_ok;
        bus.wrreq   = wr;
        bus.rdreq   = rd;
        bus.data_in = din;
        rd_ok = rd && (model_cnt != 0) && !arstn;
        wr_ok = wr && (model_cnt != DEPTH) && !arstn;
        @(posedge clk);
        if (rd_ok) begin
            exp_out = sb.pop_front();
            model_cnt--;
        end
        if (wr_ok) begin
            sb.push_back(din);
            model_cnt++;
        end
        #1;
        bus.wrreq = 1'b0;
        bus.rdreq = 1'b0;
        check_status(tag);
    endtask

    task automatic model_reset();
        sb.delete();
        model_cnt = 0;
        exp_out   = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        bus.wrreq   = 1'b0;
        bus.rdreq   = 1'b0;
        bus.data_in = '0;
        model_reset();

        // Asynchronous reset, observed before the first clock edge.
        arstn = 1'b0;
        #2 arstn = 1'b1;
        #1 check_status("reset_async");

        // Requests are ignored while reset is held.
        step(1'b1, 1'b1, 8'h55, "reset_hold");
        arstn = 1'b0;

        // Fill 1..19, no reads.
        for (int i = 1; i <= 19; i++) step(1'b1, 1'b0, DW'(i), "fill19");

        // Streaming: write 20..39 with reads; usedw stays 19.
        for (int i = 20; i <= 39; i++) step(1'b1, 1'b1, DW'(i), "stream");

        // Drain to empty (last word 39), then a read on empty holds data_out.
        while (model_cnt != 0) step(1'b0, 1'b1, 8'h00, "drain");
        check("drain_last", 32'(bus.data_out), 32'd39);
        step(1'b0, 1'b1, 8'h00, "read_empty");

        // Fill to full, overflow write ignored.
        for (int i = 0; i < int'(DEPTH); i++) step(1'b1, 1'b0, DW'(i * 7 + 3), "fill_full");
        step(1'b1, 1'b0, 8'hEE, "overflow");

        // Full + both requests: read only, full deasserts.
        step(1'b1, 1'b1, 8'h77, "full_both");

        // Read back remaining words in order.
        while (model_cnt != 0) step(1'b0, 1'b1, 8'h00, "drain_full");

        // Empty + both requests: write only, data_out unchanged.
        step(1'b1, 1'b1, 8'hAB, "empty_both");
        step(1'b0, 1'b1, 8'h00, "read_ab");

        // Mid-stream asynchronous reset discards stored words.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'(8'hC0 + i), "pre_reset");
        step(1'b0, 1'b1, 8'h00, "pre_reset_rd");
        #2 arstn = 1'b1;
        model_reset();
        #1 check_status("mid_reset");
        @(posedge clk);
        #1 arstn = 1'b0;
        check_status("post_reset");

        // Normal operation resumes; old contents are gone.
        step(1'b1, 1'b0, 8'h3C, "resume_wr");
        step(1'b0, 1'b1, 8'h00, "resume_rd");
        step(1'b0, 1'b1, 8'h00, "resume_empty_rd");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
